// File: rtl/gtfmac_wrapper_reset_sequencer.sv
// Staged reset sequencer: syncs reset_async into clk, holds every channel, then releases channels 0..NUM_CH-1 in order.
// Latency: rst_n[0] rises SYNC_STAGES+MIN_ASSERT edges after reset_async deasserts; each later channel follows by RELEASE_GAP (+ack wait).
// Backpressure: with WAIT_ACK=1 the next release waits on ch_ack of the previous channel, bounded by ACK_TIMEOUT (sticky error on expiry).
module gtfmac_wrapper_reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 3,
    parameter int MIN_ASSERT  = 8,
    parameter int RELEASE_GAP = 16,
    parameter int WAIT_ACK    = 0,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset_async,
    input  logic              sw_reset_req,
    input  logic [NUM_CH-1:0] ch_ack,
    output logic [NUM_CH-1:0] rst_n,
    output logic              done,
    output logic              ack_timeout_err
);

    localparam int CNT_MAX_MG = (MIN_ASSERT > RELEASE_GAP) ? MIN_ASSERT : RELEASE_GAP;
    localparam int CNT_MAX    = (CNT_MAX_MG > ACK_TIMEOUT) ? CNT_MAX_MG : ACK_TIMEOUT;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;
    localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic              sync_ok;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;     // most recently released channel
    logic              ackw_q,  ackw_d;    // waiting for ch_ack[idx_q]
    logic              swh_q,   swh_d;     // software reset was sampled last edge
    logic [NUM_CH-1:0] rst_q,   rst_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic [CNT_W-1:0]  hold_cnt;
    logic              rel_vld;
    logic [IDX_W-1:0]  rel_idx;

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // Reset synchroniser: shifts ones in once reset_async is released.
    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencing FSM next-state: hold window, paced releases, ack waits and software re-reset.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ackw_d   = ackw_q;
        swh_d    = 1'b0;
        rst_d    = rst_q;
        done_d   = done_q;
        err_d    = err_q;
        rel_vld  = 1'b0;
        rel_idx  = '0;
        // SYNC sees sync_ok one edge after it rises, so it acts as the cnt=0 step of HOLD
        hold_cnt = (state_q == ST_SYNC) ? '0 : cnt_q;

        case (state_q)
            ST_SYNC, ST_HOLD: begin
                // The first edge after a software request drops keeps cnt at 0 so the window starts there
                if ((state_q == ST_SYNC) ? sync_ok : !swh_q) begin
                    if (hold_cnt == MIN_LAST) begin
                        rel_vld = 1'b1;
                    end else begin
                        cnt_d   = hold_cnt + CNT_ONE;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_RELEASE: begin
                if (ackw_q) begin
                    if (ch_ack[idx_q]) begin
                        ackw_d = 1'b0;
                        cnt_d  = '0;
                    end else if (cnt_q == TO_LAST) begin
                        err_d  = 1'b1;
                        ackw_d = 1'b0;
                        cnt_d  = '0;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                    end
                end else if (cnt_q == GAP_LAST) begin
                    rel_vld = 1'b1;
                    rel_idx = idx_q + IDX_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                done_d = 1'b1;
            end
        endcase

        if (rel_vld) begin
            rst_d[rel_idx] = 1'b1;
            idx_d          = rel_idx;
            cnt_d          = '0;
            ackw_d         = (WAIT_ACK != 0);
            state_d        = (rel_idx == LAST_CH) ? ST_DONE : ST_RELEASE;
        end

        // Software re-reset wins over everything except the synchroniser phase; the error flag survives it
        if (sw_reset_req && (state_q != ST_SYNC)) begin
            rst_d   = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            ackw_d  = 1'b0;
            swh_d   = 1'b1;
            state_d = ST_HOLD;
        end
    end

    // FSM and output registers; reset_async clears everything immediately.
    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            ackw_q  <= 1'b0;
            swh_q   <= 1'b0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ackw_q  <= ackw_d;
            swh_q   <= swh_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rst_n           = rst_q;
    assign done            = done_q;
    assign ack_timeout_err = err_q;

endmodule

// File: tb/tb_gtfmac_wrapper_reset_sequencer.sv
// Directed bench for the staged reset sequencer: fixed-gap instance (a) and ack-gated instance (b).
// Expected release edges are hand-derived; outputs sampled 1 time unit after each rising edge.
// Summary line reports vectors applied and miscompares.
module tb_gtfmac_wrapper_reset_sequencer;

    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           ra_a, sw_a, done_a, err_a;
    logic [NCH-1:0] ack_a, rstn_a;
    logic           ra_b, sw_b, done_b, err_b;
    logic [NCH-1:0] ack_b, rstn_b;

    gtfmac_wrapper_reset_sequencer #(.NUM_CH(NCH)) dut_a (
        .clk             (clk),
        .reset_async     (ra_a),
        .sw_reset_req    (sw_a),
        .ch_ack          (ack_a),
        .rst_n           (rstn_a),
        .done            (done_a),
        .ack_timeout_err (err_a)
    );

    gtfmac_wrapper_reset_sequencer #(.NUM_CH(NCH), .WAIT_ACK(1), .ACK_TIMEOUT(32)) dut_b (
        .clk             (clk),
        .reset_async     (ra_b),
        .sw_reset_req    (sw_b),
        .ch_ack          (ack_b),
        .rst_n           (rstn_b),
        .done            (done_b),
        .ack_timeout_err (err_b)
    );

    int vec_cnt    = 0;
    int miscmp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH-1:0] therm(input int n);
        logic [NCH-1:0] t;
        for (int i = 0; i < NCH; i++) t[i] = (i < n);
        return t;
    endfunction

    // Channels released by offset d when ch0 goes at t0 and the rest follow every gap edges
    function automatic int rel_fixed(input int d, input int t0, input int gap);
        int r;
        if (d < t0) return 0;
        r = (d - t0) / gap + 1;
        return (r > NCH) ? NCH : r;
    endfunction

    function automatic int cnt_le(input int e, input int t0, input int t1, input int t2, input int t3);
        return int'(e >= t0) + int'(e >= t1) + int'(e >= t2) + int'(e >= t3);
    endfunction

    // Deassert reset_async mid-cycle on instance a and check the default release schedule
    task automatic run_seq_a(input string t, input int last);
        @(negedge clk);
        ra_a = 1'b1;
        for (int e = 1; e <= last; e++) begin
            tick();
            chk($sformatf("%s rst_n e%0d", t, e), rstn_a, therm(rel_fixed(e, 11, 16)));
            chk($sformatf("%s done e%0d", t, e), done_a, e >= 60);
            chk($sformatf("%s err e%0d", t, e), err_a, 0);
        end
    endtask

    initial begin
        int d;
        ra_a = 1'b0; sw_a = 1'b0; ack_a = '0;
        ra_b = 1'b0; sw_b = 1'b0; ack_b = '0;
        repeat (3) tick();
        chk("reset rst_n a", rstn_a, 0);
        chk("reset done a", done_a, 0);
        chk("reset err a", err_a, 0);
        chk("reset rst_n b", rstn_b, 0);
        chk("reset done b", done_b, 0);
        chk("reset err b", err_b, 0);

        // 1: power-up sequence, releases at 11/27/43/59, done at 60
        run_seq_a("t1", 62);

        // 2: one-cycle software re-reset from DONE
        sw_a = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            tick();
            if (k == 0) sw_a = 1'b0;
            chk($sformatf("t2 rst_n k%0d", k), rstn_a, therm(rel_fixed(k, 9, 16)));
            chk($sformatf("t2 done k%0d", k), done_a, k >= 58);
        end

        // 3: pulse, then hold the request high for 20 samples (k=31..50) during RELEASE
        sw_a = 1'b1;
        for (int k = 0; k <= 112; k++) begin
            tick();
            d = k - ((k >= 31) ? 50 : 0);
            chk($sformatf("t3 rst_n k%0d", k), rstn_a, therm(rel_fixed(d, 9, 16)));
            chk($sformatf("t3 done k%0d", k), done_a, d >= 58);
            sw_a = (k + 1 >= 31) && (k + 1 <= 50);
        end

        // 6: async reset from DONE, then mid-sequence between ch1 and ch2 releases
        @(negedge clk);
        ra_a = 1'b0;
        #1;
        chk("t6 async rst_n from done", rstn_a, 0);
        chk("t6 async done from done", done_a, 0);
        tick();
        run_seq_a("t6a", 35);
        @(negedge clk);
        ra_a = 1'b0;
        #1;
        chk("t6 async rst_n mid", rstn_a, 0);
        chk("t6 async done mid", done_a, 0);
        chk("t6 async err mid", err_a, 0);
        repeat (2) tick();
        run_seq_a("t6b", 62);

        // 4: ack-gated; ch_ack[0] first sampled 5 edges after rst_n[0], others already high
        @(negedge clk);
        ra_b = 1'b1;
        for (int e = 1; e <= 70; e++) begin
            tick();
            chk($sformatf("t4 rst_n e%0d", e), rstn_b, therm(cnt_le(e, 11, 32, 49, 66)));
            chk($sformatf("t4 done e%0d", e), done_b, e >= 67);
            chk($sformatf("t4 err e%0d", e), err_b, 0);
            if (e == 15) ack_b[0] = 1'b1;
            if (e == 20) ack_b = '1;
        end

        // 5: acks never arrive; every gap is timeout plus release gap
        @(negedge clk);
        ra_b = 1'b0;
        ack_b = '0;
        #1;
        chk("t5 reset rst_n", rstn_b, 0);
        chk("t5 reset done", done_b, 0);
        repeat (2) tick();
        @(negedge clk);
        ra_b = 1'b1;
        for (int e = 1; e <= 160; e++) begin
            tick();
            chk($sformatf("t5 rst_n e%0d", e), rstn_b, therm(cnt_le(e, 11, 59, 107, 155)));
            chk($sformatf("t5 done e%0d", e), done_b, e >= 156);
            chk($sformatf("t5 err e%0d", e), err_b, e >= 43);
        end
        sw_b = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 0) sw_b = 1'b0;
            chk($sformatf("t5 sw rst_n k%0d", k), rstn_b, therm((k >= 9) ? 1 : 0));
            chk($sformatf("t5 sw done k%0d", k), done_b, 0);
            chk($sformatf("t5 sw err sticky k%0d", k), err_b, 1);
        end
        @(negedge clk);
        ra_b = 1'b0;
        #1;
        chk("t6 b async err clear", err_b, 0);
        chk("t6 b async rst_n", rstn_b, 0);
        chk("t6 b async done", done_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
